// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
//   - req_op field positions and access-size codes
//   - resp_exc codes
//   - FSM state enum
package lsu_pkg;

    // req_op field positions
    localparam int unsigned OP_STORE_BIT = 3;
    localparam int unsigned OP_UNS_BIT   = 2;

    // Access sizes, req_op[1:0]
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Response exception codes
    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_BUS  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic for the load/store unit.
// Ports:
//   size, uns        access size code and unsigned-load flag
//   lane             low address bits selecting the starting byte
//   wdata            right-aligned store data
//   rdata            raw bus read data
//   be_c             byte enables (size mask shifted by lane)
//   wdata_c          store data replicated across all lanes
//   rdata_c          load data shifted down, truncated and extended
//   misaligned_c     address not a multiple of the access size
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB     = DATA_W / 8,
    localparam int unsigned LANE_W = $clog2(NB)
) (
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [LANE_W-1:0] lane,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c,
    output logic              misaligned_c
);

    logic [NB-1:0]     mask;
    logic [DATA_W-1:0] shifted;

    // Size decode: enables, replication, alignment
    always_comb begin
        mask         = '0;
        wdata_c      = wdata;
        misaligned_c = 1'b0;
        case (size)
            SIZE_B: begin
                mask    = NB'(32'd1);
                wdata_c = {NB{wdata[7:0]}};
            end
            SIZE_H: begin
                mask         = NB'(32'd3);
                wdata_c      = {(NB / 2){wdata[15:0]}};
                misaligned_c = lane[0];
            end
            SIZE_W: begin
                mask         = NB'(32'd15);
                wdata_c      = {(NB / 4){wdata[31:0]}};
                misaligned_c = |lane[1:0];
            end
            default: begin
                // A dword is only legal on a 64-bit bus
                mask         = '1;
                wdata_c      = wdata;
                misaligned_c = (NB < 8) || (lane != '0);
            end
        endcase
        be_c = mask << lane;
    end

    // Load extraction: bring the addressed bytes down, then extend
    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        rdata_c = shifted;
        case (size)
            SIZE_B: begin
                if (uns) rdata_c = DATA_W'(shifted[7:0]);
                else     rdata_c = DATA_W'($signed(shifted[7:0]));
            end
            SIZE_H: begin
                if (uns) rdata_c = DATA_W'(shifted[15:0]);
                else     rdata_c = DATA_W'($signed(shifted[15:0]));
            end
            SIZE_W: begin
                if (uns) rdata_c = DATA_W'(shifted[31:0]);
                else     rdata_c = DATA_W'($signed(shifted[31:0]));
            end
            default: rdata_c = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_core.sv
// lsu_core: single-outstanding load/store unit with req/gnt/rvalid bus.
// Optional watchdog: define LSU_TIMEOUT_EN to abort accesses that exceed
// TIMEOUT cycles in REQ+WAIT with a bus-error response.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_*                    M-stage access request (req_ready high in IDLE)
//   flush                    cancel the in-flight access
//   resp_*                   one-cycle response with data / exception code
//   stall                    pipeline hold
//   bus_*                    data bus request/grant/response
module lsu_core
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                flush,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_exc,
    output logic                stall,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_err
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(NB);

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [NB-1:0]       bus_be_q, bus_be_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [1:0]          resp_exc_q, resp_exc_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

    logic [3:0]          ln_op;
    logic [LANE_W-1:0]   ln_lane;
    logic [NB-1:0]       be_c;
    logic [DATA_W-1:0]   wdata_c;
    logic [DATA_W-1:0]   rdata_c;
    logic                mis_c;
    logic                timeout_c;

    // The lane logic sees the incoming request in IDLE, the captured one after
    assign ln_op   = (state_q == ST_IDLE) ? req_op : op_q;
    assign ln_lane = (state_q == ST_IDLE) ? req_addr[LANE_W-1:0] : lane_q;

    lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .size         (ln_op[1:0]),
        .uns          (ln_op[OP_UNS_BIT]),
        .lane         (ln_lane),
        .wdata        (req_wdata),
        .rdata        (bus_rdata),
        .be_c         (be_c),
        .wdata_c      (wdata_c),
        .rdata_c      (rdata_c),
        .misaligned_c (mis_c)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned WD_W = 16;
    logic [WD_W-1:0] wd_q, wd_d;

    assign timeout_c = ((state_q == ST_REQ) || (state_q == ST_WAIT)) &&
                       (wd_q == WD_W'(TIMEOUT));

    // Watchdog: restarts on entry to REQ, counts through REQ and WAIT
    always_comb begin
        wd_d = wd_q;
        if ((state_q == ST_REQ) || (state_q == ST_WAIT)) wd_d = wd_q + WD_W'(1);
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) wd_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign timeout_c = 1'b0;
`endif

    // Next-state and register-update logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        bus_we_d     = bus_we_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        resp_exc_d   = resp_exc_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    lane_d = req_addr[LANE_W-1:0];
                    if (mis_c) begin
                        state_d      = ST_RESP;
                        resp_exc_d   = req_op[OP_STORE_BIT] ? EXC_ADES : EXC_ADEL;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = ST_REQ;
                        bus_we_d    = req_op[OP_STORE_BIT];
                        bus_be_d    = be_c;
                        bus_addr_d  = req_addr & ~ADDR_W'(NB - 1);
                        bus_wdata_d = wdata_c;
                    end
                end
            end
            ST_REQ: begin
                if (flush) begin
                    // Once granted the bus owes us a response we must absorb
                    state_d = bus_gnt ? ST_DRAIN : ST_IDLE;
                end else if (bus_gnt) begin
                    state_d = ST_WAIT;
                end else if (timeout_c) begin
                    state_d      = ST_RESP;
                    resp_exc_d   = EXC_BUS;
                    resp_rdata_d = '0;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (bus_rvalid) begin
                    state_d = ST_RESP;
                    if (bus_err) begin
                        resp_exc_d   = EXC_BUS;
                        resp_rdata_d = '0;
                    end else begin
                        resp_exc_d   = EXC_NONE;
                        resp_rdata_d = op_q[OP_STORE_BIT] ? '0 : rdata_c;
                    end
                end else if (timeout_c) begin
                    state_d      = ST_RESP;
                    resp_exc_d   = EXC_BUS;
                    resp_rdata_d = '0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus_rvalid) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        bus_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            lane_q       <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            resp_exc_q   <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            resp_exc_q   <= resp_exc_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    // A flush in the RESP cycle retracts the response
    assign resp_valid = (state_q == ST_RESP) && !flush;
    assign resp_exc   = resp_exc_q;
    assign resp_rdata = resp_rdata_q;
    assign stall      = (req_valid && (state_q == ST_IDLE) && !flush) ||
                        (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_be     = bus_be_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu_core.sv
// tb_lsu_core: table-driven bench for lsu_core (DATA_W=32) with a response
// scoreboard, plus hand sequences for flush, reset and watchdog cases.
module tb_lsu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic        stall;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_gnt, bus_rvalid, bus_err;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  exc;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          gdly;
        int          rdly;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic [1:0]  exc;
        logic [31:0] rdat;
    } vec_t;

    resp_t sb_q[$];
    resp_t exp_r;
    vec_t  vecs[13];

    lsu_core #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_exc   (resp_exc),
        .stall      (stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                exp_r = sb_q.pop_front();
                chk("resp_exc", 64'(resp_exc), 64'(exp_r.exc));
                chk("resp_rdata", 64'(resp_rdata), 64'(exp_r.rdata));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        #1;
        chk("stall_on_accept", 64'(stall), 64'd1);
        chk("ready_idle", 64'(req_ready), 64'd1);
        sb_q.push_back('{exc: v.exc, rdata: v.rdat});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (v.mis) begin
            chk("mis_no_bus_req", 64'(bus_req), 64'd0);
            @(negedge clk);
            chk("mis_resp_t1", 64'(resp_valid), 64'd1);
            @(posedge clk);
            #1;
        end else begin
            for (int i = 0; i <= v.gdly; i++) begin
                if (i > 0) begin
                    @(posedge clk);
                    #1;
                end
                chk("bus_req", 64'(bus_req), 64'd1);
                chk("bus_we", 64'(bus_we), 64'(v.op[3]));
                chk("bus_be", 64'(bus_be), 64'(v.be));
                chk("bus_addr", 64'(bus_addr), 64'(v.baddr));
                chk("bus_wdata", 64'(bus_wdata), 64'(v.bwdata));
                chk("stall_req", 64'(stall), 64'd1);
            end
            bus_gnt = 1'b1;
            @(posedge clk);
            #1;
            bus_gnt = 1'b0;
            chk("bus_req_drop_after_gnt", 64'(bus_req), 64'd0);
            chk("stall_wait", 64'(stall), 64'd1);
            for (int i = 0; i < v.rdly; i++) begin
                @(posedge clk);
                #1;
                chk("stall_wait_hold", 64'(stall), 64'd1);
                chk("no_resp_in_wait", 64'(resp_valid), 64'd0);
            end
            bus_rvalid = 1'b1;
            bus_rdata  = v.rdata;
            bus_err    = v.err;
            @(posedge clk);
            #1;
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            bus_rdata  = '0;
            @(negedge clk);
            chk("resp_pulse", 64'(resp_valid), 64'd1);
            chk("stall_low_resp", 64'(stall), 64'd0);
            @(posedge clk);
            #1;
        end
        chk("resp_one_cycle", 64'(resp_valid), 64'd0);
        chk("ready_after_resp", 64'(req_ready), 64'd1);
    endtask

    initial begin
        bit seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        flush      = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        bus_err    = 1'b0;

        //          op       addr      wdata         rdata         err g  r  mis be       bwdata        baddr     exc   rdat
        vecs[0]  = '{4'b1000, 32'h103, 32'h000000AB, 32'h0,        0, 0, 0, 0, 4'b1000, 32'hABABABAB, 32'h100, 2'd0, 32'h0};
        vecs[1]  = '{4'b0001, 32'h102, 32'h0,        32'h80011234, 0, 0, 0, 0, 4'b1100, 32'h0,        32'h100, 2'd0, 32'hFFFF8001};
        vecs[2]  = '{4'b0101, 32'h102, 32'h0,        32'h80011234, 0, 1, 2, 0, 4'b1100, 32'h0,        32'h100, 2'd0, 32'h00008001};
        vecs[3]  = '{4'b0000, 32'h101, 32'h0,        32'h80011234, 0, 0, 0, 0, 4'b0010, 32'h0,        32'h100, 2'd0, 32'h00000012};
        vecs[4]  = '{4'b0010, 32'h101, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,   2'd1, 32'h0};
        vecs[5]  = '{4'b1001, 32'h003, 32'h1234,     32'h0,        0, 0, 0, 1, 4'b0000, 32'h0,        32'h0,   2'd2, 32'h0};
        vecs[6]  = '{4'b1010, 32'h204, 32'hDEADBEEF, 32'h0,        0, 3, 1, 0, 4'b1111, 32'hDEADBEEF, 32'h204, 2'd0, 32'h0};
        vecs[7]  = '{4'b0000, 32'h103, 32'h0,        32'h80011234, 0, 0, 0, 0, 4'b1000, 32'h0,        32'h100, 2'd0, 32'hFFFFFF80};
        vecs[8]  = '{4'b0100, 32'h103, 32'h0,        32'h80011234, 0, 0, 1, 0, 4'b1000, 32'h0,        32'h100, 2'd0, 32'h00000080};
        vecs[9]  = '{4'b0010, 32'h208, 32'h0,        32'h12345678, 0, 2, 0, 0, 4'b1111, 32'h0,        32'h208, 2'd0, 32'h12345678};
        vecs[10] = '{4'b0001, 32'h100, 32'h0,        32'h0000FFFF, 1, 0, 0, 0, 4'b0011, 32'h0,        32'h100, 2'd3, 32'h0};
        vecs[11] = '{4'b1001, 32'h002, 32'hFFFF1234, 32'h0,        0, 0, 0, 0, 4'b1100, 32'h12341234, 32'h0,   2'd0, 32'h0};
        vecs[12] = '{4'b1000, 32'h001, 32'hFFFFFF5A, 32'h0,        1, 1, 0, 0, 4'b0010, 32'h5A5A5A5A, 32'h0,   2'd3, 32'h0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_be", 64'(bus_be), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Stray grant/rvalid while idle are ignored
        @(negedge clk);
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        chk("idle_stray_bus_req", 64'(bus_req), 64'd0);
        chk("idle_stray_ready", 64'(req_ready), 64'd1);

        // Flush in WAIT -> DRAIN, no response, ready after rvalid
        issue(4'b0010, 32'h300, 32'h0);
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        flush   = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("drain_stall_low", 64'(stall), 64'd0);
        chk("drain_not_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("drain_holds", 64'(req_ready), 64'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        chk("drain_ready_after_rvalid", 64'(req_ready), 64'd1);
        chk("drain_no_resp", 64'(resp_valid), 64'd0);

        // Flush in REQ before grant -> back to IDLE, bus_req dropped
        issue(4'b0010, 32'h310, 32'h0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_req_bus_req", 64'(bus_req), 64'd0);
        chk("flush_req_ready", 64'(req_ready), 64'd1);

        // Flush in RESP suppresses the pulse
        issue(4'b0010, 32'h101, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_resp_suppressed", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_resp_ready", 64'(req_ready), 64'd1);

        // Async reset mid-WAIT, then a late rvalid is ignored
        issue(4'b0010, 32'h400, 32'h0);
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        chk("pre_rst_in_wait", 64'(stall), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_ready", 64'(req_ready), 64'd1);
        chk("arst_bus_req", 64'(bus_req), 64'd0);
        chk("arst_bus_addr", 64'(bus_addr), 64'd0);
        chk("arst_bus_be", 64'(bus_be), 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus_rvalid = 1'b1;
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_no_resp", 64'(resp_valid), 64'd0);
        chk("late_rvalid_ready", 64'(req_ready), 64'd1);

`ifdef LSU_TIMEOUT_EN
        // Grant never arrives: watchdog produces a bus-error response
        sb_q.push_back('{exc: 2'd3, rdata: 32'h0});
        issue(4'b0010, 32'h500, 32'h0);
        chk("to_bus_req_up", 64'(bus_req), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
                chk("to_bus_req_dropped", 64'(bus_req), 64'd0);
            end
        end
        chk("to_resp_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
`else
        seen = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on simulation length
    initial begin
        #200000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_core.md
# lsu_core

Parametrised load/store unit that replaces the purely combinational memory byte-select in the M stage. It accepts one access at a time from the pipeline and runs a request/grant/response handshake with a variable-latency data bus. It generates byte enables and lane-replicated store data, and extracts and extends load data. Misaligned accesses are flagged as AdEL/AdES exceptions, and bus errors are reported. The pipeline is stalled until the response returns.

## Interface
- DATA_W, 32, bus/data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  M-stage access request.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  access type: [3]=store, [2]=unsigned load, [1:0]=size (0 byte, 1 half, 2 word, 3 dword; dword is legal only when DATA_W=64).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- flush  in  1  cancels the in-flight access.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and exceptions.
- resp_exc  out  2  exception code: 0 none, 1 AdEL, 2 AdES, 3 bus error/timeout.
- stall  out  1  pipeline hold.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_be  out  DATA_W/8  byte enables.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_gnt  in  1  bus grant.
- bus_rvalid  in  1  read data valid or write acknowledge.
- bus_rdata  in  DATA_W  bus read data.
- bus_err  in  1  bus error; qualified by bus_rvalid.

## Operation
- States: IDLE, REQ, WAIT, RESP, DRAIN.
  - IDLE: if req_valid, capture op/addr/wdata.
    - Misaligned access (address not a multiple of the access size): go to RESP with exc=1 for loads, 2 for stores. No bus activity.
    - Otherwise go to REQ.
  - REQ: bus_req=1; bus outputs are driven from registers and held stable. On bus_gnt go to WAIT.
  - WAIT: on bus_rvalid go to RESP. Capture resp_exc=3 if bus_err, else extracted data.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - DRAIN: wait for bus_rvalid, discard it, then IDLE. No response is produced.
- Lane = addr[log2(DATA_W/8)-1:0], little-endian.
- Byte enables: the size-wide mask shifted left by lane.
- bus_wdata: store data replicated across all lanes by size.
- bus_addr: req_addr with the lane bits cleared.
- Load extraction: bus_rdata shifted right by lane×8, truncated to size, then sign-extended or zero-extended (per [2]) to DATA_W.
- Flush:
  - In REQ before grant: drop bus_req and go to IDLE.
  - In REQ with bus_gnt in the same cycle, or in WAIT: go to DRAIN.
  - In RESP: suppress resp_valid and go to IDLE.
  - Flush in IDLE is ignored.
- bus_gnt or bus_rvalid arriving in IDLE or RESP is ignored.
- stall = (req_valid & state==IDLE & ~flush) | (state is REQ or WAIT).
  - stall is low in the RESP cycle, so the pipeline advances on resp_valid.
  - stall is low in DRAIN.

## Timing
- Reset values:
  - state IDLE.
  - resp_valid=0, resp_exc=0, resp_rdata=0.
  - bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
  - req_ready=1.
  - Watchdog counter=0.
- Reset mid-transaction aborts immediately. Late bus responses are ignored afterwards.
- Accept at cycle T:
  - bus_req rises at T+1.
  - With grant at T+1 and rvalid at T+2, resp_valid is at T+3. Minimum latency is 3 cycles.
- Misaligned accept at T: resp_valid at T+1.
- req_ready goes high again the cycle after RESP or DRAIN completes.
- resp_exc and resp_rdata are valid only while resp_valid is high.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8–16-bit counter clears on entering REQ and increments in REQ and WAIT.
  - When the count reaches TIMEOUT: drop bus_req, go to RESP with exc=3.
  - Any later rvalid for that access is ignored.
  - Flush still takes priority over timeout.
- LSU_TIMEOUT_EN undefined:
  - No counter is built.
  - The unit waits indefinitely for grant and rvalid.
  - exc=3 arises only from bus_err.

## Structure
- Package lsu_pkg holds:
  - The req_op field encodings and size constants.
  - The resp_exc codes.
  - The state enum.
- Sub-module lsu_lane holds the combinational lane logic: byte-enable generation, store replication, load extraction/extension and the misalignment check, parametrised by DATA_W.
- lsu_core holds the FSM, registers and watchdog.

## Test plan
All scenarios use DATA_W=32.
- SB, addr 0x103, wdata 0xAB → bus_be=1000, bus_wdata=0xABABABAB, bus_addr=0x100, bus_we=1; resp exc=0.
- LH, addr 0x102, bus_rdata 0x8001_1234 → resp_rdata 0xFFFF8001. LHU at the same address → 0x00008001. LB at 0x101 → 0x00000012.
- LW at 0x101 → no bus_req, resp_valid at T+1 with exc=1. SH at 0x003 → exc=2.
- Grant delayed 3 cycles, rvalid 2 cycles after grant → stall held throughout, bus outputs stable, resp_valid high exactly one cycle.
- Flush in WAIT → DRAIN, no resp_valid; req_ready back the cycle after rvalid. bus_err with rvalid → exc=3.
- LSU_TIMEOUT_EN defined, TIMEOUT=8, grant never given → exc=3 response, bus_req dropped. Separately, rst asserted mid-WAIT → all outputs at reset values immediately.
